cnn_mem_responder: RTL and testbench

Synthesizable memory-side responder for the CONV accelerator port set. It holds the 4096-word input image and serves it on `iaddr`/`idata`, and it implements the five `csel`-selected result banks behind `cwr`/`crd`. It sequences the `ready`/`busy` start handshake. When `busy` falls, it streams every result bank out on a valid/ready dump port. It sits between a host loader/checker and the CONV core, and replaces the behavioural memories in FPGA and emulation builds.

---
 rtl/cnn_mem_pkg.sv | 43 ++++
 rtl/cnn_bank_ram.sv | 33 +++
 rtl/cnn_mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_cnn_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mem_pkg.sv
// Shared constants for cnn_mem_responder: bank select codes, bank depths,
// controller states and the order in which result banks are dumped.
package cnn_mem_pkg;

  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  localparam int NUM_BANKS = 5;
  localparam int IMG_DEPTH = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_e;

  // Dump order: bank select code and last address, walked front to back.
  localparam logic [2:0] DUMP_SEL  [NUM_BANKS] = '{CSEL_L0K0, CSEL_L0K1, CSEL_L1K0, CSEL_L1K1, CSEL_L2};
  localparam int         DUMP_LAST [NUM_BANKS] = '{4095, 4095, 1023, 1023, 2047};

  // Depth of result bank b (0-based, in dump order).
  function automatic int bank_depth(input int b);
    case (b)
      0, 1:    return 4096;
      2, 3:    return 1024;
      default: return 2048;
    endcase
  endfunction

  function automatic logic csel_valid(input logic [2:0] csel);
    return (csel >= CSEL_L0K0) && (csel <= CSEL_L2);
  endfunction

  function automatic logic [2:0] csel_to_bank(input logic [2:0] csel);
    return csel - 3'd1;
  endfunction

endpackage

// File: rtl/cnn_bank_ram.sv
// Single-port synchronous RAM with a registered read that returns the word
// stored before any write on the same edge.
module cnn_bank_ram #(
  parameter int DEPTH = 4096,
  parameter int DW    = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Read and optional write of one word per enabled cycle.
  // NOTE: no reset here -- the array must map onto block RAM and its contents survive reset.
  // NOTE: non-blocking assignments make the read sample the array before this edge's write.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cnn_mem_responder.sv
// Memory-side responder for the CONV core: image store, five result banks,
// ready/busy start handshake and a valid/ready dump of all banks afterwards.
module cnn_mem_responder
  import cnn_mem_pkg::*;
#(
  parameter int DW = 20,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i,
  input  logic          start_i,
  output logic          ready_o,
  input  logic          busy_i,
  input  logic [AW-1:0] iaddr_i,
  output logic [DW-1:0] idata_o,
  input  logic          cwr_i,
  input  logic [AW-1:0] caddr_wr_i,
  input  logic [DW-1:0] cdata_wr_i,
  input  logic          crd_i,
  input  logic [AW-1:0] caddr_rd_i,
  output logic [DW-1:0] cdata_rd_o,
  input  logic [2:0]    csel_i,
  output logic          dump_valid_o,
  input  logic          dump_ready_i,
  output logic [2:0]    dump_sel_o,
  output logic [AW-1:0] dump_addr_o,
  output logic [DW-1:0] dump_data_o,
  output logic          done_o
);

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } dump_word_t;

  state_e        state_q, state_d;
  logic          busy_q;
  logic          in_run, ld_ok, csel_ok;
  logic [2:0]    csel_bank;
  logic [DW-1:0] img_rdata;
  logic          img_valid_q;
  logic [DW-1:0] bank_rdata [NUM_BANKS];

  // Result read path
  logic          rd_pending_q, rd_ok_q;
  logic [2:0]    rd_bank_q;
  logic [DW-1:0] cdata_hold_q, rd_value;

  // Dump reader and two-entry skid buffer behind the RAM read latency
  logic [2:0]    dump_idx_q, infl_idx_q;
  logic [AW-1:0] dump_addr_q, infl_addr_q;
  logic          issue_done_q, infl_q;
  dump_word_t    fifo_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    count_q, occ_after;
  dump_word_t    head;
  logic          pop, issue, head_last;

  assign in_run    = (state_q == ST_RUN);
  assign ld_ok     = ld_valid_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign csel_ok   = csel_valid(csel_i);
  assign csel_bank = csel_to_bank(csel_i);

  assign head         = fifo_q[rd_ptr_q];
  assign dump_valid_o = (count_q != 2'd0);
  assign dump_sel_o   = dump_valid_o ? head.sel  : '0;
  assign dump_addr_o  = dump_valid_o ? head.addr : '0;
  assign dump_data_o  = dump_valid_o ? head.data : '0;
  assign pop          = dump_valid_o && dump_ready_i;
  assign head_last    = (head.sel == DUMP_SEL[NUM_BANKS-1]) && (head.addr == AW'(DUMP_LAST[NUM_BANKS-1]));
  // Words held after this edge; a new read may only launch if its result will find a free slot.
  assign occ_after    = count_q - 2'(pop) + 2'(infl_q);
  assign issue        = (state_q == ST_DUMP) && !issue_done_q && (occ_after <= 2'd1);

  // State register and busy edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_i;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_ARM;
      ST_ARM: begin
        ready_o = 1'b1;
        if (!busy_q && busy_i) state_d = ST_RUN;
      end
      ST_RUN:  if (busy_q && !busy_i) state_d = ST_DUMP;
      ST_DUMP: if (pop && head_last) state_d = ST_DONE;
      ST_DONE: begin
        done_o = 1'b1;
        if (start_i) state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Image store: host loads in IDLE/DONE, CONV core reads in RUN.
  cnn_bank_ram #(.DEPTH(IMG_DEPTH), .DW(DW)) u_img_ram (
    .clk     (clk),
    .en_i    (in_run || ld_ok),
    .we_i    (ld_ok),
    .addr_i  (in_run ? iaddr_i : ld_addr_i),
    .wdata_i (ld_data_i),
    .rdata_o (img_rdata)
  );

  assign idata_o = (img_valid_q && in_run) ? img_rdata : '0;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam int DEPTH = bank_depth(b);
    localparam int BW    = $clog2(DEPTH);
    logic          en, we, hit;
    logic [BW-1:0] addr;

    assign hit = in_run && csel_ok && (csel_bank == 3'(b));

    // Bank port owner: CONV core in RUN, dump reader in DUMP; upper address bits wrap.
    always_comb begin
      en   = 1'b0;
      we   = 1'b0;
      addr = '0;
      if (hit && (cwr_i || crd_i)) begin
        en   = 1'b1;
        we   = cwr_i;
        // One port: a concurrent write owns the address, so a same-cycle read sees its old word.
        addr = cwr_i ? caddr_wr_i[BW-1:0] : caddr_rd_i[BW-1:0];
      end else if (issue && (dump_idx_q == 3'(b))) begin
        en   = 1'b1;
        addr = dump_addr_q[BW-1:0];
      end
    end

    cnn_bank_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
      .clk     (clk),
      .en_i    (en),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (cdata_wr_i),
      .rdata_o (bank_rdata[b])
    );
  end

  assign rd_value   = rd_ok_q ? bank_rdata[rd_bank_q] : '0;
  assign cdata_rd_o = rd_pending_q ? rd_value : cdata_hold_q;

  // Result read bookkeeping: cdata_rd shows a fresh read for one cycle, then holds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      rd_ok_q      <= 1'b0;
      rd_bank_q    <= '0;
      cdata_hold_q <= '0;
      img_valid_q  <= 1'b0;
    end else begin
      rd_pending_q <= in_run && crd_i;
      if (in_run && crd_i) begin
        rd_ok_q   <= csel_ok;
        rd_bank_q <= csel_bank;
      end
      if (rd_pending_q) cdata_hold_q <= rd_value;
      img_valid_q <= in_run;
    end
  end

  // Dump walker and skid buffer; everything restarts whenever DUMP is left.
  always_ff @(posedge clk) begin
    if (reset || (state_q != ST_DUMP)) begin
      dump_idx_q   <= '0;
      dump_addr_q  <= '0;
      issue_done_q <= 1'b0;
      infl_q       <= 1'b0;
      infl_idx_q   <= '0;
      infl_addr_q  <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      infl_q      <= issue;
      infl_idx_q  <= dump_idx_q;
      infl_addr_q <= dump_addr_q;
      if (issue) begin
        if (dump_addr_q == AW'(DUMP_LAST[dump_idx_q])) begin
          dump_addr_q <= '0;
          if (dump_idx_q == 3'(NUM_BANKS - 1)) issue_done_q <= 1'b1;
          else                                 dump_idx_q   <= dump_idx_q + 3'd1;
        end else begin
          dump_addr_q <= dump_addr_q + AW'(1);
        end
      end
      if (infl_q) begin
        fifo_q[wr_ptr_q] <= '{sel: DUMP_SEL[infl_idx_q], addr: infl_addr_q, data: bank_rdata[infl_idx_q]};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= occ_after;
    end
  end

endmodule

// File: tb/tb_cnn_mem_responder.sv
// Self-checking bench for cnn_mem_responder with a behavioural memory model.
module tb_cnn_mem_responder;
  import cnn_mem_pkg::*;

  localparam int DW = 20;
  localparam int AW = 12;
  localparam int TOTAL_WORDS = 12288;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid, start, busy, cwr, crd, dump_ready;
  logic [AW-1:0] ld_addr, iaddr, caddr_wr, caddr_rd;
  logic [DW-1:0] ld_data, cdata_wr;
  logic [2:0]    csel;
  logic          ready, dump_valid, done;
  logic [DW-1:0] idata, cdata_rd, dump_data;
  logic [2:0]    dump_sel;
  logic [AW-1:0] dump_addr;

  always #5 clk = ~clk;

  cnn_mem_responder #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_valid_i   (ld_valid),
    .ld_addr_i    (ld_addr),
    .ld_data_i    (ld_data),
    .start_i      (start),
    .ready_o      (ready),
    .busy_i       (busy),
    .iaddr_i      (iaddr),
    .idata_o      (idata),
    .cwr_i        (cwr),
    .caddr_wr_i   (caddr_wr),
    .cdata_wr_i   (cdata_wr),
    .crd_i        (crd),
    .caddr_rd_i   (caddr_rd),
    .cdata_rd_o   (cdata_rd),
    .csel_i       (csel),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_sel_o   (dump_sel),
    .dump_addr_o  (dump_addr),
    .dump_data_o  (dump_data),
    .done_o       (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain arrays indexed by bank number (csel-1) and address modulo depth.
  logic [DW-1:0] img_m  [4096];
  logic [DW-1:0] bank_m [5][4096];
  logic [DW-1:0] cd_m;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int depth_of(input int b);
    if (b < 2) return 4096;
    if (b < 4) return 1024;
    return 2048;
  endfunction

  // Expected k-th dump word {sel, addr, data}: banks back to back in csel order.
  function automatic logic [34:0] exp_word(input int k);
    int b = 0;
    int a = k;
    while (a >= depth_of(b)) begin
      a -= depth_of(b);
      b++;
    end
    return {3'(b + 1), 12'(a), bank_m[b][a]};
  endfunction

  // One RUN-cycle access on the result port, then compare cdata_rd to the model.
  task automatic bank_op(input string tag, input bit wr, input bit rd, input logic [2:0] sel,
                         input logic [11:0] wa, input logic [19:0] wd, input logic [11:0] ra);
    bit ok = (sel >= 3'd1) && (sel <= 3'd5);
    int b  = int'(sel) - 1;
    cwr = wr; crd = rd; csel = sel; caddr_wr = wa; cdata_wr = wd; caddr_rd = ra;
    if (rd) cd_m = ok ? bank_m[b][int'(ra) % depth_of(b)] : '0;
    if (wr && ok) bank_m[b][int'(wa) % depth_of(b)] = wd;
    tick();
    cwr = 1'b0; crd = 1'b0;
    check(tag, cdata_rd, cd_m);
  endtask

  task automatic img_read(input string tag, input logic [11:0] a);
    iaddr = a;
    tick();
    check(tag, idata, img_m[a]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"},      ready,      0);
    check({tag, "_idata"},      idata,      0);
    check({tag, "_cdata_rd"},   cdata_rd,   0);
    check({tag, "_dump_valid"}, dump_valid, 0);
    check({tag, "_dump_sel"},   dump_sel,   0);
    check({tag, "_dump_addr"},  dump_addr,  0);
    check({tag, "_dump_data"},  dump_data,  0);
    check({tag, "_done"},       done,       0);
  endtask

  initial begin
    int k, cyc, first_v;
    logic v;
    logic [34:0] w;
    logic [2:0] rsel;
    bit rwr, rrd;
    logic [11:0] rwa, rra;

    reset = 1'b1; ld_valid = 0; start = 0; busy = 0; cwr = 0; crd = 0; dump_ready = 0;
    ld_addr = '0; ld_data = '0; iaddr = '0; caddr_wr = '0; caddr_rd = '0; cdata_wr = '0; csel = '0;
    cd_m = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Load IMG[a] = 3a
    for (int a = 0; a < 4096; a++) begin
      ld_valid = 1'b1; ld_addr = 12'(a); ld_data = 20'(a * 3); img_m[a] = 20'(a * 3);
      tick();
    end
    ld_valid = 1'b0;

    // ARM with busy already high: it must fall and rise again before RUN
    busy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_ready", ready, 1);
    repeat (3) tick();
    check("arm_busy_held_high", ready, 1);
    busy = 1'b0;
    tick();
    check("arm_busy_low", ready, 1);
    busy = 1'b1;
    tick();
    check("run_ready_drop", ready, 0);
    check("run_done_low", done, 0);

    img_read("idata_100", 12'd100);
    check("idata_300", idata, 20'd300);
    // Image reads while the host tries to load; loads in RUN are dropped
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1; ld_addr = (i % 2 == 0) ? 12'd100 : 12'($urandom); ld_data = 20'h0BAD0;
      img_read("idata_rand", 12'($urandom));
    end
    ld_valid = 1'b0;
    img_read("idata_100_after_drop", 12'd100);

    // Fill all banks so the dump has defined contents
    for (int b = 0; b < NUM_BANKS; b++)
      for (int a = 0; a < depth_of(b); a++)
        bank_op("fill", 1'b1, 1'b0, 3'(b + 1), 12'(a), 20'($urandom), 12'd0);

    // Bank isolation
    bank_op("l0k0_wr7", 1, 0, CSEL_L0K0, 12'd7, 20'h12345, 12'd0);
    bank_op("l0k1_wr7", 1, 0, CSEL_L0K1, 12'd7, 20'hABCDE, 12'd0);
    bank_op("l0k0_rd7", 0, 1, CSEL_L0K0, 12'd0, 20'd0, 12'd7);
    check("l0k0_own_value", cdata_rd, 20'h12345);
    bank_op("l0k1_rd7", 0, 1, CSEL_L0K1, 12'd0, 20'd0, 12'd7);
    check("l0k1_own_value", cdata_rd, 20'hABCDE);
    bank_op("csel110_rd", 0, 1, 3'b110, 12'd0, 20'd0, 12'd7);
    check("csel110_zero", cdata_rd, 20'd0);
    bank_op("csel000_wr", 1, 0, 3'b000, 12'd7, 20'hFFFFF, 12'd0);
    bank_op("l0k0_rd7_again", 0, 1, CSEL_L0K0, 12'd0, 20'd0, 12'd7);
    check("l0k0_untouched", cdata_rd, 20'h12345);
    // Wrap
    bank_op("wrap_wr", 1, 0, CSEL_L1K0, 12'h405, 20'h00055, 12'd0);
    bank_op("wrap_rd", 0, 1, CSEL_L1K0, 12'd0, 20'd0, 12'h005);
    check("wrap_l1k0", cdata_rd, 20'h00055);
    bank_op("wrap_l2_wr", 1, 0, CSEL_L2, 12'h801, 20'h0C0DE, 12'd0);
    bank_op("wrap_l2_rd", 0, 1, CSEL_L2, 12'd0, 20'd0, 12'h001);
    check("wrap_l2", cdata_rd, 20'h0C0DE);
    // Read-before-write
    bank_op("rbw_init", 1, 0, CSEL_L0K0, 12'd9, 20'h11111, 12'd0);
    bank_op("rbw_same", 1, 1, CSEL_L0K0, 12'd9, 20'h22222, 12'd9);
    check("rbw_old", cdata_rd, 20'h11111);
    bank_op("rbw_next", 0, 1, CSEL_L0K0, 12'd0, 20'd0, 12'd9);
    check("rbw_new", cdata_rd, 20'h22222);
    bank_op("hold_no_rd", 0, 0, CSEL_L0K1, 12'd0, 20'd0, 12'd7);
    check("hold_value", cdata_rd, 20'h22222);

    // Random result-port traffic; same-cycle read and write share an address
    for (int i = 0; i < 400; i++) begin
      rsel = 3'($urandom_range(0, 7));
      rwr  = 1'($urandom_range(0, 1));
      rrd  = 1'($urandom_range(0, 1));
      rwa  = 12'($urandom);
      rra  = (rwr && rrd) ? rwa : 12'($urandom);
      bank_op("rand_bank", rwr, rrd, rsel, rwa, 20'($urandom), rra);
    end

    // Dump with random backpressure
    busy = 1'b0; dump_ready = 1'b0;
    tick();
    k = 0; cyc = 0; first_v = -1;
    while (k < TOTAL_WORDS && cyc < 40000) begin
      v = dump_valid;
      w = {dump_sel, dump_addr, dump_data};
      if (v && first_v < 0) first_v = cyc;
      dump_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
      if (v && dump_ready) begin
        check("dump_word", w, exp_word(k));
        k++;
      end else if (v) begin
        check("dump_stall_stable", {dump_valid, dump_sel, dump_addr, dump_data}, {1'b1, w});
      end
    end
    dump_ready = 1'b0;
    check("dump_word_count", k, TOTAL_WORDS);
    check("dump_first_valid_within_2", (first_v >= 0) && (first_v <= 2), 1);
    check("done_after_last", done, 1);
    check("dump_valid_after_last", dump_valid, 0);

    // DONE: result port ignored, loads accepted
    crd = 1'b1; csel = CSEL_L0K0; caddr_rd = 12'd9;
    tick();
    crd = 1'b0;
    check("crd_outside_run_hold", cdata_rd, cd_m);
    cwr = 1'b1; csel = CSEL_L0K0; caddr_wr = 12'd7; cdata_wr = 20'h0BEEF;
    tick();
    cwr = 1'b0;
    ld_valid = 1'b1; ld_addr = 12'd200; ld_data = 20'h0FACE; img_m[200] = 20'h0FACE;
    tick();
    ld_valid = 1'b0;
    check("done_held", done, 1);
    check("idata_zero_outside_run", idata, 0);

    // Second run, then reset in the middle of its dump
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rearm_ready", ready, 1);
    check("rearm_done_low", done, 0);
    busy = 1'b1;
    tick();
    check("rerun_ready_drop", ready, 0);
    bank_op("cwr_outside_run_ignored", 0, 1, CSEL_L0K0, 12'd0, 20'd0, 12'd7);
    img_read("img_200_loaded_in_done", 12'd200);
    busy = 1'b0;
    tick();
    dump_ready = 1'b1;
    k = 0; cyc = 0;
    while (k < 5000 && cyc < 10000) begin
      v = dump_valid;
      w = {dump_sel, dump_addr, dump_data};
      tick();
      cyc++;
      if (v) begin
        if (k == 4999) check("dump2_word_4999", w, exp_word(k));
        k++;
      end
    end
    check("dump2_reached_5000", k, 5000);
    reset = 1'b1;
    tick();
    check_outputs_zero("mid_dump_reset");
    reset = 1'b0;
    dump_ready = 1'b0;
    cd_m = '0;
    tick();
    check("idle_after_reset_ready", ready, 0);
    check("idle_after_reset_valid", dump_valid, 0);

    // Restart without reload: image and banks retained
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_reset_arm", ready, 1);
    busy = 1'b1;
    tick();
    check("post_reset_run", ready, 0);
    img_read("retained_img_100", 12'd100);
    img_read("retained_img_200", 12'd200);
    for (int i = 0; i < 32; i++) img_read("retained_img_rand", 12'($urandom));
    for (int i = 0; i < 16; i++)
      bank_op("retained_bank", 0, 1, 3'($urandom_range(1, 5)), 12'd0, 20'd0, 12'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
